pipelined_carry_adder: RTL
==========================

Name: pipelined_carry_adder

Overview:
- Parametrised, pipelined successor to the team's 16-bit ripple-carry adder.
- Splits a WIDTH-bit add into NSEG = WIDTH/SEG_W ripple segments, one per pipeline stage, with registered carries between stages.
- Adds a valid/ready handshake with backpressure, carry-out, and a signed-overflow flag.
- Sits in datapaths that need a full-width add at high clock rate with one result per cycle.

Parameters:
- WIDTH, 32, operand and sum width in bits.
- SEG_W, 8, segment width per pipeline stage. WIDTH must be an integer multiple of SEG_W. NSEG = WIDTH/SEG_W is derived, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and cin are valid this cycle.
- in_ready  output  1  adder accepts input this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in to bit 0.
- out_valid  output  1  sum, cout and ovf hold a valid result.
- out_ready  input  1  consumer accepts the result this cycle.
- sum  output  WIDTH  (a + b + cin) mod 2^WIDTH.
- cout  output  1  carry out of bit WIDTH-1.
- ovf  output  1  two's-complement overflow.

Behaviour:
- One clock domain. Reset is asynchronous and active-high.
- Reset values:
  - all stage valid bits, out_valid, sum, cout and ovf = 0.
  - in_ready = 1 once rst deasserts, because the pipeline is empty.
- Handshake:
  - input transfer when in_valid && in_ready.
  - output transfer when out_valid && out_ready.
- Global enable: en = !out_valid || out_ready; in_ready = en.
  - When en = 0, every stage register holds, including valid bits, data and carries.
  - Bubbles are not collapsed; stalls freeze the whole pipeline.
- Stage k (k = 0..NSEG-1), when en = 1:
  - Adds segment k of its delayed a and b plus the carry from stage k-1; stage 0 uses cin.
  - Registers the SEG_W-bit partial sum, the carry-out, the already-computed lower sum bits, and the unprocessed upper operand bits.
  - Stage valid bit follows the previous stage's valid bit; stage 0 takes in_valid && in_ready.
- Latency: exactly NSEG cycles from input transfer to out_valid = 1 with no stall. Throughput is one result per cycle while out_ready = 1.
- Final stage outputs:
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR cout, registered alongside cout.
- Outputs must be stable while out_valid = 1 and out_ready = 0.
- Results emerge in acceptance order. No data is dropped or duplicated under any stall pattern.
- NSEG = 1 (SEG_W = WIDTH): single registered full-width ripple add, latency 1.
- rst asserted mid-operation: all in-flight results are discarded immediately; outputs return to reset values asynchronously.
- in_valid = 0 inserts a bubble. Bubbles propagate with valid = 0, and data fields in bubble stages are don't-care except at the output, where sum/cout/ovf hold their last value.

Test Plan:
- Reset: assert rst mid-stream with 3 results in flight -> out_valid = 0, sum = 0, cout = 0, ovf = 0 immediately; no stale result appears after rst deasserts.
- Default params: a = 0xFFFFFFFF, b = 0x00000001, cin = 0 -> exactly 4 cycles later out_valid = 1, sum = 0x00000000, cout = 1, ovf = 0. This exercises carry through all segment registers.
- Overflow: a = 0x7FFFFFFF, b = 0x00000001 -> sum = 0x80000000, cout = 0, ovf = 1. Then a = 0x80000000, b = 0x80000000 -> sum = 0x00000000, cout = 1, ovf = 1.
- Backpressure:
  - Stream 6 back-to-back adds (i + 0x10 for i = 0..5); hold out_ready = 0 from when the first result appears for 5 cycles.
  - Required: in_ready = 0 throughout, sum stays 0x10 stable.
  - Release: results 0x10..0x15 emerge in order, one per cycle, with none lost.
- WIDTH = 16, SEG_W = 16 instance:
  - 0xFFFF + 0xFFFF, cin = 1 -> sum = 0xFFFF, cout = 1, latency 1.
  - 0xAAAA + 0x5555, cin = 0 -> sum = 0xFFFF, cout = 0.
  - 0x0F0F + 0x0101, cin = 1 -> sum = 0x1011.
- WIDTH = 16, SEG_W = 4: 0x00F0 + 0x000F, alternating in_valid = 1/0 -> results 0x00FF at 4-cycle latency, with out_valid toggling to match the bubble pattern.

Source files
------------

// File: rtl/pipelined_carry_adder.sv
`default_nettype none
// ============================================================================
//  Module   : pipelined_carry_adder
//  Purpose  : WIDTH-bit adder split into NSEG ripple segments, one per stage,
//             with valid/ready handshake, carry-out and signed overflow.
//  Revision : 1.0  initial release
// ============================================================================
module pipelined_carry_adder #(
    parameter int WIDTH = 32,
    parameter int SEG_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = WIDTH / SEG_W;

    logic             w_en;
    logic [NSEG-1:0]  w_vin;
    logic [NSEG-1:0]  w_cin;
    logic [NSEG-1:0]  w_vout;
    logic [NSEG-1:0]  w_cout;
    logic [WIDTH-1:0] w_ain  [NSEG];
    logic [WIDTH-1:0] w_bin  [NSEG];
    logic [WIDTH-1:0] w_sin  [NSEG];
    logic [WIDTH-1:0] w_sout [NSEG];
    logic             w_unused;

    // A stalled output freezes every stage, bubbles included.
    assign w_en      = !w_vout[NSEG-1] || out_ready;
    assign in_ready  = w_en;
    assign out_valid = w_vout[NSEG-1];
    assign sum       = w_sout[NSEG-1];
    assign cout      = w_cout[NSEG-1];

    // The last stage only consumes the low segment of its operand window.
    assign w_unused  = ^{w_ain[NSEG-1], w_bin[NSEG-1]};

    for (genvar k = 0; k < NSEG; k++) begin : g_stage
        logic             r_v;
        logic             r_c;
        logic [WIDTH-1:0] r_s;
        logic [SEG_W:0]   w_c;
        logic [SEG_W-1:0] w_ps;
        logic [WIDTH-1:0] w_snext;

        if (k == 0) begin : g_first
            assign w_ain[k] = a;
            assign w_bin[k] = b;
            assign w_sin[k] = '0;
            assign w_cin[k] = cin;
            assign w_vin[k] = in_valid && w_en;
        end else begin : g_chain
            assign w_sin[k] = w_sout[k-1];
            assign w_cin[k] = w_cout[k-1];
            assign w_vin[k] = w_vout[k-1];
        end

        assign w_c[0] = w_cin[k];
        for (genvar i = 0; i < SEG_W; i++) begin : g_bit
            assign w_ps[i]  = w_ain[k][i] ^ w_bin[k][i] ^ w_c[i];
            assign w_c[i+1] = (w_ain[k][i] & w_bin[k][i]) |
                              (w_c[i] & (w_ain[k][i] ^ w_bin[k][i]));
        end

        always_comb begin
            w_snext                    = w_sin[k];
            w_snext[k*SEG_W +: SEG_W]  = w_ps;
        end

        // Data only moves with a valid token so the output holds over bubbles.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= 1'b0;
                r_c <= 1'b0;
                r_s <= '0;
            end else if (w_en) begin
                r_v <= w_vin[k];
                if (w_vin[k]) begin
                    r_c <= w_c[SEG_W];
                    r_s <= w_snext;
                end
            end
        end

        assign w_vout[k] = r_v;
        assign w_cout[k] = r_c;
        assign w_sout[k] = r_s;

        if (k < NSEG - 1) begin : g_fwd
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;

            // Operands shift down so the next stage always adds bits [SEG_W-1:0].
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_a <= '0;
                    r_b <= '0;
                end else if (w_en && w_vin[k]) begin
                    r_a <= w_ain[k] >> SEG_W;
                    r_b <= w_bin[k] >> SEG_W;
                end
            end

            assign w_ain[k+1] = r_a;
            assign w_bin[k+1] = r_b;
        end else begin : g_last
            logic r_ovf;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ovf <= 1'b0;
                end else if (w_en && w_vin[k]) begin
                    r_ovf <= w_c[SEG_W-1] ^ w_c[SEG_W];
                end
            end

            assign ovf = r_ovf;
        end
    end

endmodule
`default_nettype wire
